text_cursor_writer: RTL and testbench

Upstream feeder for the dual-port character RAM. Consumes a byte stream from the UART receiver through a valid/ready handshake, tracks a text cursor over a ROWS x COLS grid, and issues single-cycle write commands (we, w_row, w_col, din) to the RAM write port. It interprets printable characters and the control codes CR, LF, BS and FF. FF triggers a full-screen clear sweep that writes spaces to every cell.

---
 rtl/text_cursor_writer.sv | 189 ++++++++++++++++++
 tb/tb_text_cursor_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_writer.sv
// text_cursor_writer
//
// Purpose:
//   Upstream feeder for the dual-port character RAM. Accepts bytes from the
//   UART receiver over a valid/ready handshake, keeps a text cursor over a
//   ROWS x COLS grid and issues single-cycle write commands to the RAM write
//   port. Printable characters (0x20..0x7E) are written at the cursor and
//   advance it. CR, LF and BS move the cursor. FF clears the whole screen
//   with a row-major sweep of spaces. Any other byte is consumed and ignored.
//
// Configuration:
//   TEXTWR_BS_EN  defined   -> BS (0x08) steps back and blanks a cell
//                 undefined -> BS is consumed and ignored like any other byte
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     synchronous, active-high reset
//   rx_valid  rx_data holds a byte
//   rx_data   received character
//   rx_ready  byte is accepted when rx_valid && rx_ready
//   we        RAM write enable, one-cycle pulse per write (registered)
//   w_row     RAM write row (registered)
//   w_col     RAM write column (registered)
//   din       RAM write data (registered)
//   cur_row   current cursor row
//   cur_col   current cursor column
//   busy      clear sweep in progress

module text_cursor_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_ready,
  output logic                      we,
  output logic [$clog2(ROWS)-1:0]   w_row,
  output logic [$clog2(COLS)-1:0]   w_col,
  output logic [DATA_WIDTH-1:0]     din,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic                      busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  // Control codes are compared against the full data word, so any set bit
  // above bit 7 makes the byte fall into the "ignored" class.
  localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(8'h7E);
  localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CH_FF    = DATA_WIDTH'(8'h0C);
`ifdef TEXTWR_BS_EN
  localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8'h08);
`endif

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state;

  logic [RW-1:0] adv_row;
  logic [CW-1:0] adv_col;
  logic [RW-1:0] next_line_row;
  logic [RW-1:0] sweep_row;
  logic [CW-1:0] sweep_col;
  logic          sweep_done;
  logic          is_printable;

  // The upstream may only hand over a byte while we sit in IDLE and are not
  // being reset; during the clear sweep it has to hold its byte.
  assign rx_ready = (state == IDLE) && !reset;

  // Next-position arithmetic. The cursor advance and the clear sweep use the
  // same row-major stepping with wrap from the last row back to row 0. The
  // sweep steps from the cell currently on the write port, so the write
  // address registers double as the sweep counter.
  always_comb begin
    next_line_row = (cur_row == LAST_ROW) ? '0 : cur_row + RW'(1);
    adv_row       = cur_row;
    adv_col       = cur_col + CW'(1);
    if (cur_col == LAST_COL) begin
      adv_row = next_line_row;
      adv_col = '0;
    end
    sweep_row = w_row;
    sweep_col = w_col + CW'(1);
    if (w_col == LAST_COL) begin
      sweep_row = w_row + RW'(1);
      sweep_col = '0;
    end
    sweep_done   = (w_row == LAST_ROW) && (w_col == LAST_COL);
    is_printable = (rx_data >= CH_SPACE) && (rx_data <= CH_TILDE);
  end

  // Main state machine. Every write is scheduled one cycle ahead, so an
  // accepted byte shows up on the RAM port in the following cycle. FF
  // schedules the first sweep write (cell 0,0) directly, which lets the sweep
  // cover all ROWS*COLS cells in the ROWS*COLS cycles right after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we      <= 1'b0;
      w_row   <= '0;
      w_col   <= '0;
      din     <= '0;
      cur_row <= '0;
      cur_col <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we <= 1'b0;
          if (rx_valid) begin
            if (is_printable) begin
              we      <= 1'b1;
              w_row   <= cur_row;
              w_col   <= cur_col;
              din     <= rx_data;
              cur_row <= adv_row;
              cur_col <= adv_col;
            end else if (rx_data == CH_CR) begin
              cur_col <= '0;
            end else if (rx_data == CH_LF) begin
              cur_row <= next_line_row;
              cur_col <= '0;
`ifdef TEXTWR_BS_EN
            end else if (rx_data == CH_BS) begin
              if (cur_col != '0) begin
                cur_col <= cur_col - CW'(1);
                we      <= 1'b1;
                w_row   <= cur_row;
                w_col   <= cur_col - CW'(1);
                din     <= CH_SPACE;
              end else if (cur_row != '0) begin
                cur_row <= cur_row - RW'(1);
                cur_col <= LAST_COL;
                we      <= 1'b1;
                w_row   <= cur_row - RW'(1);
                w_col   <= LAST_COL;
                din     <= CH_SPACE;
              end
`endif
            end else if (rx_data == CH_FF) begin
              state   <= CLEAR;
              busy    <= 1'b1;
              cur_row <= '0;
              cur_col <= '0;
              we      <= 1'b1;
              w_row   <= '0;
              w_col   <= '0;
              din     <= CH_SPACE;
            end
          end
        end

        CLEAR: begin
          if (sweep_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            we    <= 1'b0;
          end else begin
            we    <= 1'b1;
            w_row <= sweep_row;
            w_col <= sweep_col;
            din   <= CH_SPACE;
          end
        end

        default: begin
          state <= IDLE;
          we    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// tb_text_cursor_writer
//
// Purpose:
//   Self-checking bench for text_cursor_writer with the default 4 x 32 grid
//   and 8-bit characters. Directed bytes are driven through the rx handshake;
//   the RAM write each byte should cause is queued at stimulus time and a
//   separate monitor pops and compares on every we pulse. Cursor, handshake
//   and busy values are checked directly after each step.

module tb_text_cursor_writer;

  localparam int ROWS = 4;
  localparam int COLS = 32;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       we;
  logic [1:0] w_row;
  logic [4:0] w_col;
  logic [7:0] din;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;

  typedef struct packed {
    logic [1:0] row;
    logic [4:0] col;
    logic [7:0] data;
  } wr_t;

  wr_t expq[$];
  int  vectors;
  int  miscompares;

  text_cursor_writer #(
    .DATA_WIDTH(8),
    .ROWS(ROWS),
    .COLS(COLS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .we(we),
    .w_row(w_row),
    .w_col(w_col),
    .din(din),
    .cur_row(cur_row),
    .cur_col(cur_col),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every we pulse must match the oldest queued write, and a
  // pulse with nothing queued is itself an error.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_we: got row=%0d col=%0d din=%02h, required no write",
                 w_row, w_col, din);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if ({w_row, w_col, din} !== {e.row, e.col, e.data}) begin
          miscompares++;
          $display("[TB] FAIL ram_write: got row=%0d col=%0d din=%02h, required row=%0d col=%0d din=%02h",
                   w_row, w_col, din, e.row, e.col, e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic checkCursor(input string name, input int r, input int c);
    checkOutput({name, "_row"}, int'(cur_row), r);
    checkOutput({name, "_col"}, int'(cur_col), c);
  endtask

  // Drives one byte for one cycle (called #1 after a rising edge while the
  // DUT is ready) and queues the write it should produce, if any.
  task automatic applyStimulus(input logic [7:0] data, input bit exp_we,
                               input int r, input int c, input logic [7:0] exp_din);
    wr_t e;
    rx_valid = 1'b1;
    rx_data  = data;
    if (exp_we) begin
      e.row  = 2'(r);
      e.col  = 5'(c);
      e.data = exp_din;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    checkOutput($sformatf("we_after_%02h", data), int'(we), int'(exp_we));
  endtask

  // Queues the first n cells of the row-major clear sweep.
  task automatic queueSweep(input int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.row  = 2'(k / COLS);
      e.col  = 5'(k % COLS);
      e.data = 8'h20;
      expq.push_back(e);
    end
  endtask

  initial begin
    int cnt;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_we", int'(we), 0);
    checkOutput("reset_w_row", int'(w_row), 0);
    checkOutput("reset_w_col", int'(w_col), 0);
    checkOutput("reset_din", int'(din), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_rx_ready", int'(rx_ready), 0);
    checkCursor("reset_cursor", 0, 0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", int'(rx_ready), 1);
    @(posedge clk);
    #1;

    // Basic back-to-back writes
    $display("[TB] basic write");
    applyStimulus(8'h41, 1, 0, 0, 8'h41);
    applyStimulus(8'h42, 1, 0, 1, 8'h42);
    checkCursor("basic_cursor", 0, 2);

    // Row wrap and grid wrap
    $display("[TB] wrap");
    applyStimulus(8'h0D, 0, 0, 0, 8'h00);
    checkCursor("cr_home", 0, 0);
    for (int i = 0; i < COLS; i++) applyStimulus(8'h2E, 1, 0, i, 8'h2E);
    checkCursor("row_wrap_cursor", 1, 0);
    applyStimulus(8'h43, 1, 1, 0, 8'h43);
    checkCursor("after_43", 1, 1);
    applyStimulus(8'h0A, 0, 0, 0, 8'h00);
    applyStimulus(8'h0A, 0, 0, 0, 8'h00);
    checkCursor("two_lf", 3, 0);
    for (int i = 0; i < COLS - 1; i++) applyStimulus(8'h7E, 1, 3, i, 8'h7E);
    checkCursor("last_cell_cursor", 3, 31);
    applyStimulus(8'h44, 1, 3, 31, 8'h44);
    checkCursor("grid_wrap_cursor", 0, 0);

    // CR / LF
    $display("[TB] cr lf");
    applyStimulus(8'h41, 1, 0, 0, 8'h41);
    applyStimulus(8'h0D, 0, 0, 0, 8'h00);
    checkCursor("cr_cursor", 0, 0);
    applyStimulus(8'h0A, 0, 0, 0, 8'h00);
    checkCursor("lf_cursor", 1, 0);
    applyStimulus(8'h42, 1, 1, 0, 8'h42);
    checkCursor("crlf_cursor", 1, 1);

    // Backspace across a row boundary
    $display("[TB] backspace");
`ifdef TEXTWR_BS_EN
    applyStimulus(8'h08, 1, 1, 0, 8'h20);
    checkCursor("bs_col", 1, 0);
    applyStimulus(8'h08, 1, 0, 31, 8'h20);
    checkCursor("bs_row", 0, 31);
    applyStimulus(8'h58, 1, 0, 31, 8'h58);
    applyStimulus(8'h59, 1, 1, 0, 8'h59);
`else
    applyStimulus(8'h08, 0, 0, 0, 8'h00);
    checkCursor("bs_ignored", 1, 1);
    applyStimulus(8'h08, 0, 0, 0, 8'h00);
    checkCursor("bs_ignored2", 1, 1);
    applyStimulus(8'h58, 1, 1, 1, 8'h58);
    applyStimulus(8'h59, 1, 1, 2, 8'h59);
`endif

    // Full clear
    $display("[TB] clear");
    queueSweep(ROWS * COLS);
    applyStimulus(8'h0C, 1, 0, 0, 8'h20);
    expq.pop_back();
    checkOutput("clear_busy_first", int'(busy), 1);
    checkCursor("clear_cursor", 0, 0);
    cnt = 0;
    while (rx_ready == 1'b0 && cnt < 200) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput("clear_ready_low_cycles", cnt, ROWS * COLS);
    checkOutput("clear_busy_after", int'(busy), 0);
    checkOutput("clear_queue_drained", expq.size(), 0);
    checkCursor("after_clear", 0, 0);

    // BS at home, then BS after two characters
    applyStimulus(8'h08, 0, 0, 0, 8'h00);
    checkCursor("bs_home", 0, 0);
    applyStimulus(8'h5A, 1, 0, 0, 8'h5A);
    applyStimulus(8'h59, 1, 0, 1, 8'h59);
`ifdef TEXTWR_BS_EN
    applyStimulus(8'h08, 1, 0, 1, 8'h20);
    checkCursor("bs_after_zy", 0, 1);
`else
    applyStimulus(8'h08, 0, 0, 0, 8'h00);
    checkCursor("bs_after_zy", 0, 2);
`endif

    // Ignored bytes
    $display("[TB] ignored bytes");
    cnt = int'(cur_col);
    applyStimulus(8'h7F, 0, 0, 0, 8'h00);
    applyStimulus(8'h1F, 0, 0, 0, 8'h00);
    applyStimulus(8'hFF, 0, 0, 0, 8'h00);
    checkOutput("ignored_row", int'(cur_row), 0);
`ifdef TEXTWR_BS_EN
    checkOutput("ignored_col", int'(cur_col), 1);
`else
    checkOutput("ignored_col", int'(cur_col), 2);
`endif

    // Reset during the sweep: only the first 10 cells get written
    $display("[TB] reset mid-clear");
    queueSweep(10);
    applyStimulus(8'h0C, 1, 0, 0, 8'h20);
    expq.pop_back();
    repeat (9) @(posedge clk);
    #1;
    checkOutput("sweep_busy_cycle10", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_we", int'(we), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_rx_ready", int'(rx_ready), 0);
    checkCursor("abort_cursor", 0, 0);
    reset = 1'b0;
    #1;
    checkOutput("abort_ready_back", int'(rx_ready), 1);
    @(posedge clk);
    #1;
    applyStimulus(8'h51, 1, 0, 0, 8'h51);
    checkCursor("after_abort", 0, 1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
